mfp_adc_max10_model: RTL and testbench

Synthesizable stand-in for the Altera MAX10 ADC hard IP. It accepts the command stream driven by the ADC controller core and returns one response per accepted command after a fixed conversion delay. Response data is deterministic, so controller-core benches and FPGA targets without an ADC can run closed-loop. It connects directly to the controller's `ADC_C_*` outputs and `ADC_R_*` inputs.

---
 rtl/mfp_adc_max10_model.sv | 139 +++++++++++++
 tb/tb_mfp_adc_max10_model.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mfp_adc_max10_model.sv
// Behavioural stand-in for the MAX10 ADC hard IP: queues commands and returns one
// response per command after a fixed conversion delay, with deterministic data.
module mfp_adc_max10_model #(
  parameter int CONV_CYCLES = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ADC_C_Valid,
  input  logic [4:0]  ADC_C_Channel,
  input  logic        ADC_C_SOP,
  input  logic        ADC_C_EOP,
  output logic        ADC_C_Ready,
  output logic        ADC_R_Valid,
  output logic [4:0]  ADC_R_Channel,
  output logic [11:0] ADC_R_Data,
  output logic        ADC_R_SOP,
  output logic        ADC_R_EOP
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CONV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
  logic          full, empty, push, pop, done;
  logic [6:0]    cur_reg;
  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [6:0]    seq_reg, seq_next;

  logic          r_valid_reg, r_sop_reg, r_eop_reg;
  logic [4:0]    r_channel_reg;
  logic [11:0]   r_data_reg;

  assign empty       = (wr_ptr_reg == rd_ptr_reg);
  assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign ADC_C_Ready = ~full;
  // A pop in the same cycle never makes room for a push: ready is pointer-only.
  assign push        = ADC_C_Valid & ~full;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Storage and the current-command register carry no reset; state gates their use.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= {ADC_C_Channel, ADC_C_SOP, ADC_C_EOP};
    if (pop)  cur_reg <= mem[rd_ptr_reg[AW-1:0]];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      seq_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      seq_reg   <= seq_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    seq_next   = seq_reg;
    pop        = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = CONV;
        end
      end
      CONV: begin
        if (cnt_reg == '0) begin
          done       = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      RESP: begin
        seq_next = seq_reg + 7'd1;
        if (!empty) begin
          pop        = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = CONV;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Response registers load on the last CONV cycle so they are visible during RESP.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_valid_reg   <= 1'b0;
      r_channel_reg <= '0;
      r_sop_reg     <= 1'b0;
      r_eop_reg     <= 1'b0;
      r_data_reg    <= '0;
    end else if (done) begin
      r_valid_reg   <= 1'b1;
      r_channel_reg <= cur_reg[6:2];
      r_sop_reg     <= cur_reg[1];
      r_eop_reg     <= cur_reg[0];
      r_data_reg    <= {cur_reg[6:2], seq_reg};
    end else begin
      r_valid_reg   <= 1'b0;
      r_channel_reg <= '0;
      r_sop_reg     <= 1'b0;
      r_eop_reg     <= 1'b0;
      r_data_reg    <= '0;
    end
  end

  assign ADC_R_Valid   = r_valid_reg;
  assign ADC_R_Channel = r_channel_reg;
  assign ADC_R_SOP     = r_sop_reg;
  assign ADC_R_EOP     = r_eop_reg;
  assign ADC_R_Data    = r_data_reg;

endmodule

// File: tb/tb_mfp_adc_max10_model.sv
// Directed bench for mfp_adc_max10_model (CONV_CYCLES=4, FIFO_DEPTH=4).
module tb_mfp_adc_max10_model;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_valid, c_sop, c_eop;
  logic [4:0]  c_ch;
  logic        c_ready;
  logic        r_valid, r_sop, r_eop;
  logic [4:0]  r_ch;
  logic [11:0] r_data;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [4:0]  ch;
    logic        sop;
    logic        eop;
    logic [11:0] data;
  } rsp_t;
  rsp_t rsp_q[$];

  mfp_adc_max10_model #(.CONV_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .CLK(clk), .RESET(rst),
    .ADC_C_Valid(c_valid), .ADC_C_Channel(c_ch), .ADC_C_SOP(c_sop), .ADC_C_EOP(c_eop),
    .ADC_C_Ready(c_ready),
    .ADC_R_Valid(r_valid), .ADC_R_Channel(r_ch), .ADC_R_Data(r_data),
    .ADC_R_SOP(r_sop), .ADC_R_EOP(r_eop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (r_valid === 1'b1) rsp_q.push_back(rsp_t'({r_ch, r_sop, r_eop, r_data}));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] ch, input logic sop, input logic eop);
    c_valid = 1'b1; c_ch = ch; c_sop = sop; c_eop = eop;
    cyc();
    c_valid = 1'b0; c_sop = 1'b0; c_eop = 1'b0;
  endtask

  initial begin
    int nxt;
    int acc;
    int bp_rdy[10];
    logic [11:0] bp_data[6];

    rst = 1'b1; c_valid = 1'b0; c_ch = '0; c_sop = 1'b0; c_eop = 1'b0;
    #1;
    check("rst_valid", 32'(r_valid), 32'd0);
    check("rst_data",  32'(r_data),  32'd0);
    check("rst_ch",    32'(r_ch),    32'd0);
    check("rst_sopeop", 32'({r_sop, r_eop}), 32'd0);
    check("rst_ready", 32'(c_ready), 32'd1);
    cyc(); cyc();
    rst = 1'b0;

    // Single conversion: ch17, response six cycles after acceptance, seq=0
    c_valid = 1'b1; c_ch = 5'd17; c_sop = 1'b1; c_eop = 1'b1;
    check("single_ready_t", 32'(c_ready), 32'd1);
    cyc();
    c_valid = 1'b0; c_sop = 1'b0; c_eop = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      check("single_valid", 32'(r_valid), (k == 6) ? 32'd1 : 32'd0);
      check("single_ready", 32'(c_ready), 32'd1);
      if (k == 6) begin
        check("single_ch",   32'(r_ch),   32'd17);
        check("single_sop",  32'(r_sop),  32'd1);
        check("single_eop",  32'(r_eop),  32'd1);
        check("single_data", 32'(r_data), 32'h880);
      end
      if (k == 7) check("single_data_idle", 32'(r_data), 32'd0);
      cyc();
    end

    // Back-to-back ch1..3: responses at +6, +11, +16; seq 1..3
    send(5'd1, 1'b1, 1'b0);
    send(5'd2, 1'b0, 1'b0);
    send(5'd3, 1'b0, 1'b1);
    for (int k = 3; k <= 18; k++) begin
      check("b2b_valid", 32'(r_valid), (k == 6 || k == 11 || k == 16) ? 32'd1 : 32'd0);
      if (k == 6) begin
        check("b2b_ch1",   32'(r_ch),   32'd1);
        check("b2b_data1", 32'(r_data), 32'h081);
        check("b2b_sop1",  32'({r_sop, r_eop}), 32'b10);
      end
      if (k == 11) begin
        check("b2b_ch2",   32'(r_ch),   32'd2);
        check("b2b_data2", 32'(r_data), 32'h102);
        check("b2b_sop2",  32'({r_sop, r_eop}), 32'b00);
      end
      if (k == 16) begin
        check("b2b_ch3",   32'(r_ch),   32'd3);
        check("b2b_data3", 32'(r_data), 32'h183);
        check("b2b_sop3",  32'({r_sop, r_eop}), 32'b01);
      end
      cyc();
    end

    // Backpressure: Valid held 10 cycles, channels 8.. offered in order
    rsp_q.delete();
    bp_rdy  = '{1, 1, 1, 1, 1, 0, 0, 1, 0, 0};
    bp_data = '{12'h404, 12'h485, 12'h506, 12'h587, 12'h608, 12'h689};
    nxt = 8;
    for (int k = 0; k < 10; k++) begin
      c_valid = 1'b1; c_ch = 5'(nxt); c_sop = (nxt == 8); c_eop = (nxt == 13);
      check("bp_ready", 32'(c_ready), 32'(bp_rdy[k]));
      cyc();
      if (bp_rdy[k] == 1) nxt++;
    end
    c_valid = 1'b0; c_sop = 1'b0; c_eop = 1'b0;
    for (int k = 0; k < 25; k++) cyc();
    check("bp_count", 32'(rsp_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < rsp_q.size()) begin
        check("bp_ch",   32'(rsp_q[i].ch),   32'(8 + i));
        check("bp_data", 32'(rsp_q[i].data), 32'(bp_data[i]));
        check("bp_sop",  32'(rsp_q[i].sop),  (i == 0) ? 32'd1 : 32'd0);
        check("bp_eop",  32'(rsp_q[i].eop),  (i == 5) ? 32'd1 : 32'd0);
      end
    end

    // Idle hold: 50 quiet cycles, then seq must still be 10
    for (int k = 0; k < 50; k++) begin
      check("idle_valid", 32'(r_valid), 32'd0);
      check("idle_ready", 32'(c_ready), 32'd1);
      cyc();
    end
    rsp_q.delete();
    send(5'd2, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) cyc();
    check("idle_rsp_count", 32'(rsp_q.size()), 32'd1);
    if (rsp_q.size() > 0) check("idle_rsp_data", 32'(rsp_q[0].data), 32'h10A);

    // Sequence wrap: reset, then 130 ch0 conversions
    rst = 1'b1; cyc(); rst = 1'b0;
    rsp_q.delete();
    acc = 0;
    for (int k = 0; k < 2000 && rsp_q.size() < 130; k++) begin
      c_valid = (acc < 130); c_ch = 5'd0;
      if (c_valid && c_ready) acc++;
      cyc();
    end
    c_valid = 1'b0;
    check("wrap_count", 32'(rsp_q.size()), 32'd130);
    if (rsp_q.size() >= 130) begin
      check("wrap_128", 32'(rsp_q[127].data), 32'h07F);
      check("wrap_129", 32'(rsp_q[128].data), 32'h000);
      check("wrap_130", 32'(rsp_q[129].data), 32'h001);
    end

    // Reset two cycles into CONV with two commands queued
    rsp_q.delete();
    send(5'd20, 1'b1, 1'b0);
    send(5'd21, 1'b0, 1'b0);
    send(5'd22, 1'b0, 1'b1);
    cyc();
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(r_valid), 32'd0);
    check("mid_rst_ready", 32'(c_ready), 32'd1);
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 30; k++) cyc();
    check("mid_rst_no_rsp", 32'(rsp_q.size()), 32'd0);
    send(5'd5, 1'b0, 1'b0);
    for (int k = 1; k < 6; k++) cyc();
    check("post_rst_valid", 32'(r_valid), 32'd1);
    check("post_rst_ch",    32'(r_ch),    32'd5);
    check("post_rst_data",  32'(r_data),  32'h280);

    // Asynchronous clear of a live response, mid-cycle
    #2 rst = 1'b1;
    #1;
    check("async_valid", 32'(r_valid), 32'd0);
    check("async_data",  32'(r_data),  32'd0);
    check("async_ch",    32'(r_ch),    32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    check("async_after_valid", 32'(r_valid), 32'd0);
    check("async_after_ready", 32'(c_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
